// File: rtl/parity_mem_pkg.sv
// Shared definitions for the parity-protected memory: default geometry and
// even-parity encode/check helpers sized to the widest supported word.
package parity_mem_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_ERRCNT_W = 8;
    localparam int MAX_DATA_W   = 64;

    // Returns {parity, data} with the parity bit placed at position 'width'.
    // Bits of 'data' at or above 'width' are ignored. Callers cast the result
    // down to their own width+1.
    function automatic logic [MAX_DATA_W:0] calc_even_parity(
        input logic [MAX_DATA_W-1:0] data,
        input int                    width
    );
        logic [MAX_DATA_W-1:0] mask;
        logic [MAX_DATA_W-1:0] kept;
        logic                  par;
        if (width >= MAX_DATA_W) begin
            mask = {MAX_DATA_W{1'b1}};
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        kept = data & mask;
        par  = ^kept;
        return {1'b0, kept} | ({{MAX_DATA_W{1'b0}}, par} << width);
    endfunction

    // A stored word is good when its total bit count is even.
    function automatic logic check_even_parity(input logic [MAX_DATA_W:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/parity_mem_ctrl_sat_counter.sv
// Saturating up-counter used for the parity-error tally. Stops at all-ones.
module parity_mem_ctrl_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear first, then increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {WIDTH{1'b0}};
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/parity_mem_ctrl.sv
// Single-port synchronous memory storing {even parity, data} per word.
// Reads take one cycle and return data with valid / parity-error /
// uninitialised flags; out-of-range accesses raise addr_err.
module parity_mem_ctrl
    import parity_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ERRCNT_W = DEF_ERRCNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write,
    input  logic                read,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                inj_err,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid,
    output logic                parity_err,
    output logic                uninit,
    output logic                addr_err,
    output logic [ERRCNT_W-1:0] err_count
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    // Storage: contents survive reset, only the written flags are cleared.
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q;
    logic [DEPTH-1:0]  written_d;

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              uninit_q, uninit_d;
    logic              addr_err_q, addr_err_d;

    logic              addr_ok_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              err_inc_s;
    logic [DATA_W:0]   wr_word_s;
    logic [DATA_W:0]   rd_word_s;

    assign addr_ok_s = ({1'b0, address} < DEPTH_L);
    assign wr_en_s   = write & addr_ok_s;
    // Write wins over a simultaneous read.
    assign rd_en_s   = read & ~write;
    assign rd_word_s = mem_q[address];

    // Encode the write word; inj_err flips the parity bit to plant an error.
    always_comb begin
        wr_word_s = (DATA_W+1)'(calc_even_parity(64'(data_in), DATA_W))
                  ^ {inj_err, {DATA_W{1'b0}}};
    end

    // Written-flag update for in-range writes.
    always_comb begin
        written_d = written_q;
        if (wr_en_s) begin
            written_d[address] = 1'b1;
        end else begin
            written_d = written_q;
        end
    end

    // Read response: pulses default low, data_out holds between reads.
    always_comb begin
        data_out_d   = data_out_q;
        rd_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        uninit_d     = 1'b0;
        addr_err_d   = (write | read) & ~addr_ok_s;
        if (rd_en_s) begin
            rd_valid_d = 1'b1;
            if (addr_ok_s && written_q[address]) begin
                data_out_d   = rd_word_s[DATA_W-1:0];
                parity_err_d = check_even_parity((MAX_DATA_W+1)'(rd_word_s));
                uninit_d     = 1'b0;
            end else begin
                data_out_d   = {DATA_W{1'b0}};
                parity_err_d = 1'b0;
                uninit_d     = 1'b1;
            end
        end else begin
            data_out_d = data_out_q;
        end
    end

    // Count errors on the same edge that reports them.
    assign err_inc_s = rd_valid_d & parity_err_d;

    // Array write port; reset blocks the write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem_q[address] <= wr_word_s;
        end
    end

    // Flag and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            written_q    <= {DEPTH{1'b0}};
            data_out_q   <= {DATA_W{1'b0}};
            rd_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            uninit_q     <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            written_q    <= written_d;
            data_out_q   <= data_out_d;
            rd_valid_q   <= rd_valid_d;
            parity_err_q <= parity_err_d;
            uninit_q     <= uninit_d;
            addr_err_q   <= addr_err_d;
        end
    end

    parity_mem_ctrl_sat_counter #(
        .WIDTH (ERRCNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (1'b0),
        .inc_i   (err_inc_s),
        .count_o (err_count)
    );

    assign data_out   = data_out_q;
    assign rd_valid   = rd_valid_q;
    assign parity_err = parity_err_q;
    assign uninit     = uninit_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_parity_mem_ctrl.sv
// Bench for parity_mem_ctrl: an 8-bit / 200-word instance checked against an
// array-based reference model, plus a 32-bit instance checked directly.
module tb_parity_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write, read, inj_err;
    logic [7:0]  address, data_in;
    logic [7:0]  data_out;
    logic        rd_valid, parity_err, uninit, addr_err;
    logic [7:0]  err_count;

    logic        write2, read2, inj2;
    logic [7:0]  addr2;
    logic [31:0] din2, dout2;
    logic        rv2, pe2, un2, ae2;
    logic [7:0]  cnt2;

    int vectors;
    int miscompares;

    // Reference model state (main instance, DEPTH = 200)
    logic [7:0]  m_data [256];
    logic        m_bad  [256];
    logic        m_wr   [256];
    logic [7:0]  m_dout;
    int          m_cnt;
    logic [19:0] exp_vec, obs_vec;

    always #5 clk = ~clk;

    parity_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .ERRCNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .write(write), .read(read), .address(address),
        .data_in(data_in), .inj_err(inj_err), .data_out(data_out), .rd_valid(rd_valid),
        .parity_err(parity_err), .uninit(uninit), .addr_err(addr_err), .err_count(err_count)
    );

    parity_mem_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .ERRCNT_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .write(write2), .read(read2), .address(addr2),
        .data_in(din2), .inj_err(inj2), .data_out(dout2), .rd_valid(rv2),
        .parity_err(pe2), .uninit(un2), .addr_err(ae2), .err_count(cnt2)
    );

    function automatic logic [19:0] pack(input logic v, input logic [7:0] d, input logic pe,
                                         input logic un, input logic ae, input logic [7:0] c);
        return {v, d, pe, un, ae, c};
    endfunction

    // Apply one cycle to the main instance and advance the model.
    task automatic step(input logic rst, input logic w, input logic r,
                        input logic [7:0] a, input logic [7:0] d, input logic inj);
        logic ev, epe, eun, eae;
        rst_n = rst; write = w; read = r; address = a; data_in = d; inj_err = inj;
        ev = 1'b0; epe = 1'b0; eun = 1'b0; eae = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
            m_cnt  = 0;
            m_dout = 8'h00;
        end else begin
            if ((w || r) && a >= 200) eae = 1'b1;
            if (w) begin
                if (a < 200) begin
                    m_data[a] = d;
                    m_bad[a]  = inj;
                    m_wr[a]   = 1'b1;
                end
            end else if (r) begin
                ev = 1'b1;
                if (a < 200 && m_wr[a]) begin
                    m_dout = m_data[a];
                    epe    = m_bad[a];
                end else begin
                    m_dout = 8'h00;
                    eun    = 1'b1;
                end
                if (epe && m_cnt < 255) m_cnt++;
            end
        end
        exp_vec = pack(ev, m_dout, epe, eun, eae, 8'(m_cnt));
        @(negedge clk);
        obs_vec = pack(rd_valid, data_out, parity_err, rd_valid & uninit, addr_err, err_count);
    endtask

    task automatic step2(input logic w, input logic r, input logic [7:0] a,
                         input logic [31:0] d, input logic inj);
        write2 = w; read2 = r; addr2 = a; din2 = d; inj2 = inj;
        @(negedge clk);
        write2 = 1'b0; read2 = 1'b0; inj2 = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 8'h10, 8'h55, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0);
        vectors++;
        if (obs_vec !== 20'h00000 || obs_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL reset_state got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_basic();
        step(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL basic_write_quiet got=%h want=%h", obs_vec, exp_vec);
        end
        step(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || data_out !== 8'hA5 || rd_valid !== 1'b1 || uninit !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_read got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_uninit();
        step(1'b1, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || uninit !== 1'b1 || data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL uninit_read got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_inject_sat();
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h20, 8'h3C, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || parity_err !== 1'b1 || err_count !== 8'd1 || data_out !== 8'h3C) begin
            miscompares++;
            $display("FAIL inject_first got=%h want=%h", obs_vec, exp_vec);
        end
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL inject_repeat[%0d] got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL err_count_saturate got=%0d want=255", err_count);
        end
    endtask

    task automatic test_rw_same();
        step(1'b1, 1'b1, 1'b1, 8'h11, 8'h7E, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_same_no_valid got=%h want=%h", obs_vec, exp_vec);
        end
        step(1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || data_out !== 8'h7E) begin
            miscompares++;
            $display("FAIL rw_same_readback got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_addr_err();
        step(1'b1, 1'b1, 1'b0, 8'd200, 8'hFF, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || addr_err !== 1'b1 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_err_write got=%h want=%h", obs_vec, exp_vec);
        end
        step(1'b1, 1'b0, 1'b1, 8'd200, 8'h00, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || addr_err !== 1'b1 || uninit !== 1'b1 || data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL addr_err_read got=%h want=%h", obs_vec, exp_vec);
        end
        step(1'b1, 1'b0, 1'b0, 8'd200, 8'h00, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_err_pulse got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_reset_flags();
        step(1'b1, 1'b1, 1'b0, 8'h01, 8'h12, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cycle_read got=%h want=%h", obs_vec, exp_vec);
        end
        step(1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || uninit !== 1'b1 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_clears_written got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 1'b0, 8'(8'h80 + i), 8'($urandom_range(0, 255)), (i == 3) ? 1'b1 : 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(8'h80 + i), 8'h00, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL back_to_back[%0d] got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        logic       w, r, inj, rst;
        logic [7:0] a;
        for (int i = 0; i < 400; i++) begin
            w   = ($urandom_range(0, 2) == 0);
            r   = ($urandom_range(0, 1) == 0);
            inj = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 59) != 0);
            a   = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'(8'd190 + $urandom_range(0, 15));
            step(rst, w, r, a, 8'($urandom_range(0, 255)), inj);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random[%0d] got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_w32();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step2(1'b1, 1'b0, 8'h03, 32'hDEADBEEF, 1'b0);
        vectors++;
        if (rv2 !== 1'b0) begin
            miscompares++;
            $display("FAIL w32_write_quiet got rd_valid=%b want 0", rv2);
        end
        step2(1'b0, 1'b1, 8'h03, 32'h0, 1'b0);
        vectors++;
        if (rv2 !== 1'b1 || dout2 !== 32'hDEADBEEF || pe2 !== 1'b0 || un2 !== 1'b0 || cnt2 !== 8'd0) begin
            miscompares++;
            $display("FAIL w32_read got v=%b d=%h pe=%b un=%b c=%0d want v=1 d=deadbeef pe=0 un=0 c=0",
                     rv2, dout2, pe2, un2, cnt2);
        end
        step2(1'b1, 1'b0, 8'h04, 32'h0BADF00D, 1'b1);
        step2(1'b0, 1'b1, 8'h04, 32'h0, 1'b0);
        vectors++;
        if (rv2 !== 1'b1 || dout2 !== 32'h0BADF00D || pe2 !== 1'b1 || cnt2 !== 8'd1) begin
            miscompares++;
            $display("FAIL w32_inject got v=%b d=%h pe=%b c=%0d want v=1 d=0badf00d pe=1 c=1",
                     rv2, dout2, pe2, cnt2);
        end
        step2(1'b0, 1'b1, 8'h09, 32'h0, 1'b0);
        vectors++;
        if (rv2 !== 1'b1 || dout2 !== 32'h0 || un2 !== 1'b1 || pe2 !== 1'b0 || ae2 !== 1'b0) begin
            miscompares++;
            $display("FAIL w32_uninit got v=%b d=%h un=%b pe=%b ae=%b want v=1 d=0 un=1 pe=0 ae=0",
                     rv2, dout2, un2, pe2, ae2);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; write = 1'b0; read = 1'b0; inj_err = 1'b0;
        address = 8'h00; data_in = 8'h00;
        write2 = 1'b0; read2 = 1'b0; inj2 = 1'b0; addr2 = 8'h00; din2 = 32'h0;
        m_cnt = 0; m_dout = 8'h00;
        for (int i = 0; i < 256; i++) begin
            m_data[i] = 8'h00; m_bad[i] = 1'b0; m_wr[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_uninit();
        test_inject_sat();
        test_rw_same();
        test_addr_err();
        test_reset_flags();
        test_back_to_back();
        test_random();
        test_w32();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
